// File: rtl/ysyx_220053_trap_pkg.sv
// Shared CSR addresses, op encodings, trap causes, sequencer states and mstatus field helpers
// for the trap/return sequencer.
package ysyx_220053_trap_pkg;

   localparam int XLEN = 64;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;

   typedef enum logic [2:0] {
      CSR_OP_WRITE = 3'b000,
      CSR_OP_SET   = 3'b001,
      CSR_OP_CLEAR = 3'b010
   } csr_op_e;

   localparam logic [XLEN-1:0] MCAUSE_ECALL_M = 64'd11;
   localparam logic [XLEN-1:0] MCAUSE_MTIMER  = 64'h8000_0000_0000_0007;

   typedef enum logic [2:0] {
      IDLE, T_EPC, T_CAUSE, T_VEC, T_JUMP, M_READ, M_JUMP
   } trap_state_e;

   typedef struct packed {
      logic [1:0] mpp;
      logic       mpie;
      logic       mie;
   } mstatus_f_t;

   function automatic mstatus_f_t mstatus_apply(input logic [2:0] op, input mstatus_f_t cur,
                                                input mstatus_f_t d);
      case (op)
         CSR_OP_WRITE: return d;
         CSR_OP_SET:   return cur | d;
         CSR_OP_CLEAR: return cur & ~d;
         default:      return cur;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] mstatus_image(input mstatus_f_t f);
      logic [XLEN-1:0] img;
      img        = '0;
      img[3]     = f.mie;
      img[7]     = f.mpie;
      img[12:11] = f.mpp;
      return img;
   endfunction

endpackage

// File: rtl/ysyx_220053_mstatus_reg.sv
// mstatus MIE/MPIE/MPP holder: trap entry beats mret exit beats an instruction write.
// Updates land on the next clock; mstatus_out is the registered image.
module ysyx_220053_mstatus_reg
   import ysyx_220053_trap_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            trap_enter,
   input  logic            mret_exit,
   input  logic            inst_wen,
   input  logic [2:0]      inst_op,
   input  mstatus_f_t      inst_data,
   output logic [XLEN-1:0] mstatus_out
);

   mstatus_f_t fields_q, fields_d;

   always_comb begin
      fields_d = fields_q;
      if (trap_enter) begin
         fields_d.mpie = fields_q.mie;
         fields_d.mie  = 1'b0;
         fields_d.mpp  = 2'b11;
      end else if (mret_exit) begin
         fields_d.mie  = fields_q.mpie;
         fields_d.mpie = 1'b1;
         fields_d.mpp  = 2'b11;
      end else if (inst_wen) begin
         fields_d = mstatus_apply(inst_op, fields_q, inst_data);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fields_q <= '{mpp: 2'b11, mpie: 1'b0, mie: 1'b0};
      end else begin
         fields_q <= fields_d;
      end
   end

   assign mstatus_out = mstatus_image(fields_q);

endmodule

// File: rtl/ysyx_220053_trap_ctrl.sv
// Trap/mret sequencer sharing the CSR file port with instruction CSR accesses.
// Trap redirects 4 cycles after acceptance, mret 2 cycles; stall holds the pipeline meanwhile.
module ysyx_220053_trap_ctrl
   import ysyx_220053_trap_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            ecall_req,
   input  logic            mret_req,
   input  logic            timer_irq,
   input  logic [XLEN-1:0] pc_in,
   input  logic            inst_csr_wen,
   input  logic [11:0]     inst_csr_id,
   input  logic [2:0]      inst_csr_op,
   input  logic [XLEN-1:0] inst_csr_data,
   output logic [XLEN-1:0] inst_csr_rdata,
   output logic            csr_wen,
   output logic [11:0]     csr_id,
   output logic [2:0]      csr_op,
   output logic [XLEN-1:0] csr_data,
   input  logic [XLEN-1:0] csr_rdata,
   output logic            stall,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            trap_ack,
   output logic [XLEN-1:0] mstatus_out
);

   trap_state_e     state_q, state_d;
   logic [XLEN-1:0] cause_q, cause_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic [XLEN-1:0] ret_pc_q, ret_pc_d;
   logic [XLEN-1:2] vec_q, vec_d;

   logic is_idle, take_timer, trap_enter, accept, mst_wen;

   assign is_idle    = (state_q == IDLE);
   assign take_timer = timer_irq & mstatus_out[3];
   assign trap_enter = is_idle & (take_timer | ecall_req);
   assign accept     = is_idle & (take_timer | ecall_req | mret_req);
   // Instruction writes to mstatus never reach the CSR file; this block owns those bits.
   assign mst_wen    = is_idle & ~accept & inst_csr_wen & (inst_csr_id == CSR_MSTATUS);

   ysyx_220053_mstatus_reg u_mstatus (
      .clk        (clk),
      .rst        (rst),
      .trap_enter (trap_enter),
      .mret_exit  (state_q == M_JUMP),
      .inst_wen   (mst_wen),
      .inst_op    (inst_csr_op),
      .inst_data  ('{mpp: inst_csr_data[12:11], mpie: inst_csr_data[7], mie: inst_csr_data[3]}),
      .mstatus_out(mstatus_out)
   );

   always_comb begin
      state_d  = state_q;
      cause_d  = cause_q;
      epc_d    = epc_q;
      ret_pc_d = ret_pc_q;
      vec_d    = vec_q;
      case (state_q)
         IDLE: begin
            if (trap_enter) begin
               state_d = T_EPC;
               cause_d = take_timer ? MCAUSE_MTIMER : MCAUSE_ECALL_M;
               epc_d   = pc_in;
            end else if (mret_req) begin
               state_d = M_READ;
            end
         end
         T_EPC:   state_d = T_CAUSE;
         T_CAUSE: state_d = T_VEC;
         T_VEC: begin
            vec_d   = csr_rdata[XLEN-1:2];
            state_d = T_JUMP;
         end
         M_READ: begin
            ret_pc_d = csr_rdata;
            state_d  = M_JUMP;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cause_q  <= '0;
         epc_q    <= '0;
         ret_pc_q <= '0;
         vec_q    <= '0;
      end else begin
         state_q  <= state_d;
         cause_q  <= cause_d;
         epc_q    <= epc_d;
         ret_pc_q <= ret_pc_d;
         vec_q    <= vec_d;
      end
   end

   always_comb begin
      csr_wen  = 1'b0;
      csr_id   = inst_csr_id;
      csr_op   = inst_csr_op;
      csr_data = inst_csr_data;
      case (state_q)
         IDLE:    csr_wen = inst_csr_wen & ~accept & (inst_csr_id != CSR_MSTATUS);
         T_EPC: begin
            csr_wen  = 1'b1;
            csr_id   = CSR_MEPC;
            csr_op   = CSR_OP_WRITE;
            csr_data = epc_q;
         end
         T_CAUSE: begin
            csr_wen  = 1'b1;
            csr_id   = CSR_MCAUSE;
            csr_op   = CSR_OP_WRITE;
            csr_data = cause_q;
         end
         T_VEC:   csr_id = CSR_MTVEC;
         M_READ:  csr_id = CSR_MEPC;
         default: ;
      endcase
   end

   assign stall          = ~is_idle | accept;
   assign redirect_valid = (state_q == T_JUMP) | (state_q == M_JUMP);
   assign trap_ack       = redirect_valid;
   assign redirect_pc    = (state_q == T_JUMP) ? {vec_q, 2'b00} :
                           (state_q == M_JUMP) ? ret_pc_q : '0;
   assign inst_csr_rdata = (inst_csr_id == CSR_MSTATUS) ? mstatus_out : csr_rdata;

endmodule
